// File: rtl/block_xfer_seq.sv
// LDM/STM block transfer sequencer: walks the register list in ascending order,
// issuing word accesses and driving the banked register file's read/write ports.
module block_xfer_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load,
  input  logic        up,
  input  logic        pre,
  input  logic        wb,
  input  logic        s_bit,
  input  logic [15:0] reg_list,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [4:0]  mode_in,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  rf_rn,
  input  logic [31:0] rf_rn_data,
  output logic [3:0]  rf_rd,
  output logic [31:0] rf_rd_data,
  output logic        rf_reg_write,
  output logic [4:0]  rf_mode
);

  typedef enum logic [2:0] {IDLE, SETUP, RDREG, MEM, WB, DONE} state_t;

  state_t      state;
  state_t      finish_state;
  logic        load_q, up_q, pre_q, wb_q, base_in_list;
  logic [15:0] list_q;
  logic [3:0]  base_reg_q;
  logic [31:0] base_q, base_fin;
  logic [4:0]  cnt;
  logic [31:0] span, raw_start, start_addr, final_base;
  logic [3:0]  cur_idx, next_idx;
  logic [15:0] rest;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i] && !found) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 16; i++) cnt = cnt + {4'b0, list_q[i]};
    span = {25'b0, cnt, 2'b00};
    case ({up_q, pre_q})
      2'b10:   raw_start = base_q;
      2'b11:   raw_start = base_q + 32'd4;
      2'b00:   raw_start = base_q - span + 32'd4;
      default: raw_start = base_q - span;
    endcase
    start_addr   = {raw_start[31:2], 2'b00};
    final_base   = up_q ? base_q + span : base_q - span;
    cur_idx      = lowest(list_q);
    rest         = list_q & ~(16'd1 << cur_idx);
    next_idx     = lowest(rest);
    finish_state = (wb_q && !base_in_list) ? WB : DONE;
  end

  assign mem_wdata = mem_req ? rf_rn_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      load_q       <= 1'b0;
      up_q         <= 1'b0;
      pre_q        <= 1'b0;
      wb_q         <= 1'b0;
      base_in_list <= 1'b0;
      list_q       <= '0;
      base_reg_q   <= '0;
      base_q       <= '0;
      base_fin     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      rf_rn        <= '0;
      rf_rd        <= '0;
      rf_rd_data   <= '0;
      rf_reg_write <= 1'b0;
      rf_mode      <= '0;
    end else begin
      done         <= 1'b0;
      rf_reg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            load_q       <= load;
            up_q         <= up;
            pre_q        <= pre;
            wb_q         <= wb;
            list_q       <= reg_list;
            base_reg_q   <= base_reg;
            base_q       <= base_addr;
            base_in_list <= load & reg_list[base_reg];
            rf_mode      <= (s_bit && !(load && reg_list[15])) ? 5'b10000 : mode_in;
            busy         <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          mem_addr <= start_addr;
          base_fin <= final_base;
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (load_q) begin
            state   <= MEM;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end else begin
            state <= RDREG;
            rf_rn <= cur_idx;
          end
        end
        RDREG: begin
          state   <= MEM;
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
        end
        MEM: begin
          if (mem_ack) begin
            list_q <= rest;
            if (load_q) begin
              rf_reg_write <= 1'b1;
              rf_rd        <= cur_idx;
              rf_rd_data   <= mem_rdata;
            end
            // LDM stays in MEM with the request held; STM must re-read through RDREG
            if (rest == '0) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= finish_state;
              done    <= (finish_state == DONE);
            end else begin
              mem_addr <= mem_addr + 32'd4;
              if (!load_q) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                rf_rn   <= next_idx;
                state   <= RDREG;
              end
            end
          end
        end
        WB: begin
          rf_reg_write <= 1'b1;
          rf_rd        <= base_reg_q;
          rf_rd_data   <= base_fin;
          done         <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Scoreboard bench for block_xfer_seq: expected memory accesses and register
// file writes are queued per scenario and popped as the DUT produces them.
module tb_block_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, load = 1'b0, up = 1'b0, pre = 1'b0, wb = 1'b0, s_bit = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_addr = '0;
  logic [4:0]  mode_in = '0;
  logic        busy, done, mem_req, mem_we, rf_reg_write;
  logic [31:0] mem_addr, mem_wdata, rf_rd_data;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [3:0]  rf_rn, rf_rd;
  logic [31:0] rf_rn_data = '0;
  logic [4:0]  rf_mode;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_t;
  typedef struct {logic [3:0] rd; logic [31:0] data;} rf_t;
  mem_t exp_mem[$];
  rf_t  exp_rf[$];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int stall_idx = -1;
  int stall_left = 0;
  logic [31:0] regs[16];

  block_xfer_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load), .up(up), .pre(pre),
    .wb(wb), .s_bit(s_bit), .reg_list(reg_list), .base_reg(base_reg),
    .base_addr(base_addr), .mode_in(mode_in), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_rn(rf_rn), .rf_rn_data(rf_rn_data),
    .rf_rd(rf_rd), .rf_rd_data(rf_rd_data), .rf_reg_write(rf_reg_write), .rf_mode(rf_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // register file read port model: one posedge of latency
  always @(posedge clk) rf_rn_data <= regs[rf_rn];

  // memory responder and scoreboard consumer, both at negedge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst_n && mem_req) begin
      if (acc_cnt == stall_idx && stall_left > 0) begin
        stall_left--;
      end else begin
        mem_ack   = 1'b1;
        mem_rdata = mdata(mem_addr);
        acc_cnt++;
        checks++;
        if (exp_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: got we=%0b addr=%h, required no access", mem_we, mem_addr);
        end else begin
          mem_t e;
          e = exp_mem.pop_front();
          if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
            errors++;
            $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
          end
        end
      end
    end
    if (rst_n && rf_reg_write) begin
      checks++;
      if (exp_rf.size() == 0) begin
        errors++;
        $display("FAIL rf_unexpected: got rd=%0d data=%h, required no write", rf_rd, rf_rd_data);
      end else begin
        rf_t r;
        r = exp_rf.pop_front();
        if (rf_rd !== r.rd || rf_rd_data !== r.data) begin
          errors++;
          $display("FAIL rf_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_rd_data, r.rd, r.data);
        end
      end
    end
  end

  // drive a one-cycle start; returns at the negedge of the SETUP cycle (cycle 1)
  task automatic do_start(input logic l, input logic u, input logic p, input logic w,
                          input logic s, input logic [15:0] lst, input logic [3:0] br,
                          input logic [31:0] ba, input logic [4:0] md);
    load = l; up = u; pre = p; wb = w; s_bit = s;
    reg_list = lst; base_reg = br; base_addr = ba; mode_in = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we, rf_reg_write, mem_addr, mem_wdata, rf_rn, rf_rd, rf_rd_data, rf_mode} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b req=%0b addr=%h wr=%0b mode=%b, required all 0",
               busy, done, mem_req, mem_addr, rf_reg_write, rf_mode);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ldm_basic;
    int cyc;
    exp_mem.push_back('{1'b0, 32'h1000, 32'h0});
    exp_mem.push_back('{1'b0, 32'h1004, 32'h0});
    exp_mem.push_back('{1'b0, 32'h1008, 32'h0});
    exp_rf.push_back('{4'd1, mdata(32'h1000)});
    exp_rf.push_back('{4'd2, mdata(32'h1004)});
    exp_rf.push_back('{4'd3, mdata(32'h1008)});
    exp_rf.push_back('{4'd0, 32'h100C});
    do_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000E, 4'd0, 32'h1000, 5'b10011);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ldm_busy_setup: got %0b, required 1", busy);
    end
    @(negedge clk);
    // a second start while busy must be ignored
    start = 1'b1; load = 1'b0; reg_list = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL ldm_done_cycle: got %0d, required 6", cyc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ldm_done_pulse: got done=%0b busy=%0b, required 0 0", done, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ldm_drain: got mem_left=%0d rf_left=%0d busy=%0b, required 0 0 0",
               exp_mem.size(), exp_rf.size(), busy);
    end
  endtask

  task automatic test_stm_down_pre;
    int cyc;
    exp_mem.push_back('{1'b1, 32'h1FF8, regs[0]});
    exp_mem.push_back('{1'b1, 32'h1FFC, regs[15]});
    exp_rf.push_back('{4'd13, 32'h1FF8});
    do_start(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8001, 4'd13, 32'h2000, 5'b10010);
    checks++;
    if (rf_mode !== 5'b10010) begin
      errors++;
      $display("FAIL stm_rf_mode: got %b, required 10010", rf_mode);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL stm_done_cycle: got %0d, required 7", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
      errors++;
      $display("FAIL stm_drain: got mem_left=%0d rf_left=%0d, required 0 0", exp_mem.size(), exp_rf.size());
    end
  endtask

  task automatic test_ldm_base_in_list;
    int cyc;
    exp_mem.push_back('{1'b0, 32'h3000, 32'h0});
    exp_rf.push_back('{4'd2, mdata(32'h3000)});
    do_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 4'd2, 32'h3000, 5'b10011);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL base_in_list_done_cycle: got %0d, required 3", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_rf.size() != 0 || exp_mem.size() != 0) begin
      errors++;
      $display("FAIL base_in_list_drain: got rf_left=%0d mem_left=%0d, required 0 0", exp_rf.size(), exp_mem.size());
    end
  endtask

  task automatic test_empty_list;
    int cyc;
    do_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd5, 32'h4444, 5'b10011);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL empty_done_cycle: got %0d, required 2", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_s_bit;
    int cyc;
    exp_mem.push_back('{1'b1, 32'h4000, regs[8]});
    do_start(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 4'd0, 32'h4000, 5'b10001);
    checks++;
    if (rf_mode !== 5'b10000) begin
      errors++;
      $display("FAIL sbit_stm_mode: got %b, required 10000", rf_mode);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc !== 4 || rf_mode !== 5'b10000) begin
      errors++;
      $display("FAIL sbit_stm_done: got cycle=%0d mode=%b, required 4 10000", cyc, rf_mode);
    end
    repeat (2) @(negedge clk);
    exp_mem.push_back('{1'b0, 32'h5000, 32'h0});
    exp_mem.push_back('{1'b0, 32'h5004, 32'h0});
    exp_rf.push_back('{4'd8, mdata(32'h5000)});
    exp_rf.push_back('{4'd15, mdata(32'h5004)});
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8100, 4'd0, 32'h5000, 5'b10001);
    checks++;
    if (rf_mode !== 5'b10001) begin
      errors++;
      $display("FAIL sbit_ldm_mode: got %b, required 10001", rf_mode);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL sbit_ldm_done_cycle: got %0d, required 4", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
      errors++;
      $display("FAIL sbit_drain: got mem_left=%0d rf_left=%0d, required 0 0", exp_mem.size(), exp_rf.size());
    end
  endtask

  task automatic test_wait_and_reset;
    int cyc;
    int n;
    acc_cnt = 0; stall_idx = 1; stall_left = 3;
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{1'b0, 32'h6000 + 32'(4 * i), 32'h0});
      exp_rf.push_back('{4'(4 + i), mdata(32'h6000 + 32'(4 * i))});
    end
    do_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00F0, 4'd1, 32'h6000, 5'b10011);
    n = 0;
    while (!(mem_req && mem_addr == 32'h6004) && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h6004 || busy !== 1'b1 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL wait_stable: got req=%0b addr=%h busy=%0b we=%0b, required 1 00006004 1 0",
                 mem_req, mem_addr, busy, mem_we);
      end
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_req, mem_we, rf_reg_write, mem_addr, mem_wdata, rf_rd, rf_rd_data, rf_rn, rf_mode} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got busy=%0b req=%0b addr=%h wr=%0b rd=%0d mode=%b, required all 0",
               busy, mem_req, mem_addr, rf_reg_write, rf_rd, rf_mode);
    end
    exp_mem.delete();
    exp_rf.delete();
    stall_idx = -1; stall_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d busy/done cycles, required 0", n);
    end
    exp_mem.push_back('{1'b0, 32'h7000, 32'h0});
    exp_mem.push_back('{1'b0, 32'h7004, 32'h0});
    exp_rf.push_back('{4'd0, mdata(32'h7000)});
    exp_rf.push_back('{4'd1, mdata(32'h7004)});
    exp_rf.push_back('{4'd4, 32'h7008});
    do_start(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 4'd4, 32'h7000, 5'b10011);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL restart_done_cycle: got %0d, required 5", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
      errors++;
      $display("FAIL restart_drain: got mem_left=%0d rf_left=%0d, required 0 0", exp_mem.size(), exp_rf.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE_0000 + 32'(i * 17);
    @(negedge clk);
    test_reset();
    test_ldm_basic();
    test_stm_down_pre();
    test_ldm_base_in_list();
    test_empty_list();
    test_s_bit();
    test_wait_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_xfer_seq.md
# block_xfer_seq

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It walks a 16-bit register list in ascending order and generates word addresses. It drives the banked register file's read port for stores and its write port for loads and base writeback. It sits between the instruction decoder and the register file / memory interface, acting as the register file's access initiator.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- load  in  1  1 = LDM, 0 = STM.
- up, pre, wb, s_bit  in  1 each  U/P/W/S instruction bits.
- reg_list  in  16  bit i = register i transferred.
- base_reg  in  4  Rn index.
- base_addr  in  32  current Rn value.
- mode_in  in  5  current CPSR mode.
- busy  out  1  high from the cycle after start until the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address, bits[1:0] = 0.
- mem_wdata  out  32  store data; equals rf_rn_data while mem_req.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  completes the current request.
- rf_rn  out  4  register file read index.
- rf_rn_data  in  32  register file read data; one posedge of latency.
- rf_rd  out  4  register file write index.
- rf_rd_data  out  32  register file write data.
- rf_reg_write  out  1  register file write enable; one-cycle pulse.
- rf_mode  out  5  bank select presented to the register file.

## Operation
- FSM states: IDLE, SETUP, RDREG, MEM, WB, DONE.
- **IDLE.** On start: latch all inputs, then go to SETUP. start is ignored in every other state.
- **SETUP (1 cycle).** Compute n = popcount(reg_list) and the start address (computed mod 2^32, then bits[1:0] cleared):
  - up & !pre: base
  - up & pre: base+4
  - !up & !pre: base−4n+4
  - !up & pre: base−4n
- **SETUP exits.**
  - Final base = up ? base+4n : base−4n.
  - n = 0 → DONE. No memory access, no write.
  - Otherwise: STM → RDREG, LDM → MEM.
- **RDREG (STM, 1 cycle).** rf_rn = lowest remaining index; then go to MEM. rf_rn is held through MEM.
- **MEM.** mem_req = 1 and mem_we = !load; hold all memory outputs until mem_ack.
  - STM on ack: advance the address by 4, then go to RDREG or finish.
  - LDM on ack: register the write for the next cycle (rf_rd = index, rf_rd_data = mem_rdata, rf_reg_write = 1). Then go to MEM for the next register, or finish.
- **Finish.**
  - wb = 1, and not (load and reg_list[base_reg]) → WB.
  - Otherwise → DONE. An LDM with base_reg in the list suppresses writeback; the loaded value wins.
- **WB (1 cycle).** rf_reg_write = 1, rf_rd = base_reg, rf_rd_data = final base.
- **DONE (1 cycle).** done = 1, busy = 1; then IDLE.
- **Banking.** rf_mode = 5'b10000 (USER) when s_bit & !(load & reg_list[15]); otherwise latched mode_in. The value is held constant for the whole operation.
- **Ordering.** Registers always go in ascending index order at ascending addresses.
- **Bus idle.** mem_ack outside MEM is ignored.

## Timing
- **Reset values.** All outputs are 0, state is IDLE.
- **Reset mid-operation.** mem_req and rf_reg_write drop immediately (asynchronous). No done pulse is produced, and latched state is discarded.
- **LDM latency** (ack in the same cycle as req), start edge to done: 1 (SETUP) + n (MEM) + [1 WB] + 1 (DONE) cycles.
  - The last register write pulse overlaps the WB or DONE cycle; writes never collide, because WB follows one cycle after the last write is registered.
- **STM latency.** 1 + 2n + [1] + 1 cycles with zero-wait memory.
- **Wait states.** Each cycle without ack adds one cycle; outputs are stable throughout.
- **rf_reg_write.** Never high for two different indices in the same cycle.
- **Register file write timing.** The register file writes on negedge, so data and index are stable for the full high phase of the pulse cycle.

## Test plan
- **LDM, up, no pre, wb.** base = 0x1000, list = 0x000E, base_reg = 0, zero-wait memory returning A, B, C:
  - addresses 0x1000, 0x1004, 0x1008;
  - writes r1 = A, r2 = B, r3 = C, then r0 = 0x100C;
  - done on cycle 6 after start.
- **STM, down, pre, wb.** base = 0x2000, list = 0x8001, base_reg = 13, mode = IRQ:
  - rf_mode = 10010;
  - stores r0 to 0x1FF8 and r15 to 0x1FFC;
  - WB writes r13 = 0x1FF8.
- **LDM with base in list.** base_reg = 2, list = 0x0004, wb = 1 → single write to r2 with the memory data; no WB cycle.
- **Empty list.** list = 0 → done two cycles after start; mem_req and rf_reg_write stay 0.
- **S bit.** s_bit = 1, mode = FIQ:
  - STM of r8 → rf_mode = 10000.
  - LDM list = 0x8100 → rf_mode = 10001.
- **Wait states and reset.** Hold mem_ack low for 3 cycles mid-LDM → address stable, busy held. Then assert rst_n = 0 → all outputs 0 within the same cycle; a later start runs a full operation from the beginning.
